sdram_fifo_sched: RTL



---
 rtl/sdram_fifo_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sdram_fifo_sched.sv
// Burst request scheduler between the user write/read FIFOs and an SDRAM controller.
// Keeps one request outstanding, alternates directions on ties, and wraps linear burst addresses.
module sdram_fifo_sched #(
  parameter logic [23:0] WR_BASE     = 24'd0,
  parameter logic [23:0] WR_END      = 24'd1024,
  parameter logic [23:0] RD_BASE     = 24'd0,
  parameter logic [23:0] RD_END      = 24'd1024,
  parameter logic [9:0]  WR_BURST    = 10'd10,
  parameter logic [9:0]  RD_BURST    = 10'd10,
  parameter logic [9:0]  RD_FIFO_THR = 10'd10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [9:0]  wr_fifo_cnt,
  input  logic [9:0]  rd_fifo_cnt,
  input  logic        read_valid,
  input  logic        addr_clr,
  output logic        sdram_wr_req,
  output logic [23:0] sdram_wr_addr,
  output logic [9:0]  wr_burst_len,
  input  logic        sdram_wr_ack,
  output logic        sdram_rd_req,
  output logic [23:0] sdram_rd_addr,
  output logic [9:0]  rd_burst_len,
  input  logic        sdram_rd_ack,
  output logic        sched_busy
);

  typedef enum logic [2:0] {IDLE, ARB, WR_REQ, WR_RUN, RD_REQ, RD_RUN} state_t;

  state_t      state_q;
  logic        wr_req_q, rd_req_q, busy_q;
  logic        last_wr_q, wr_seen_q;
  logic        wr_ack_q, rd_ack_q;
  logic [23:0] wr_addr_q, rd_addr_q;
  logic [23:0] wr_addr_d, rd_addr_d;
  logic        wr_ok, rd_ok, wr_done, rd_done, pick_wr;

  // The next burst must fit entirely below the region end, otherwise restart at base.
  function automatic logic [23:0] advance(input logic [23:0] addr, input logic [9:0] burst,
                                          input logic [23:0] base, input logic [23:0] end_addr);
    logic [24:0] nxt;
    nxt = {1'b0, addr} + {15'd0, burst};
    if (nxt + {15'd0, burst} > {1'b0, end_addr}) return base;
    return nxt[23:0];
  endfunction

  assign wr_addr_d = advance(wr_addr_q, WR_BURST, WR_BASE, WR_END);
  assign rd_addr_d = advance(rd_addr_q, RD_BURST, RD_BASE, RD_END);

  assign wr_ok   = init_end & (wr_fifo_cnt >= WR_BURST);
  assign rd_ok   = init_end & read_valid & wr_seen_q & (rd_fifo_cnt < RD_FIFO_THR);
  assign pick_wr = wr_ok & (~rd_ok | ~last_wr_q);
  assign wr_done = wr_ack_q & ~sdram_wr_ack;
  assign rd_done = rd_ack_q & ~sdram_rd_ack;

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      last_wr_q <= 1'b0;
      wr_seen_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_addr_q <= WR_BASE;
      rd_addr_q <= RD_BASE;
    end else begin
      wr_ack_q <= sdram_wr_ack;
      rd_ack_q <= sdram_rd_ack;
      unique case (state_q)
        IDLE: begin
          if (addr_clr) begin
            wr_addr_q <= WR_BASE;
            rd_addr_q <= RD_BASE;
            wr_seen_q <= 1'b0;
          end
          if (init_end) state_q <= ARB;
        end
        ARB: begin
          // A clear takes the whole ARB cycle so no request goes out with a stale address.
          if (addr_clr) begin
            wr_addr_q <= WR_BASE;
            rd_addr_q <= RD_BASE;
            wr_seen_q <= 1'b0;
          end else if (pick_wr) begin
            state_q  <= WR_REQ;
            wr_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (rd_ok) begin
            state_q  <= RD_REQ;
            rd_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        WR_REQ: if (sdram_wr_ack) begin
          wr_req_q <= 1'b0;
          state_q  <= WR_RUN;
        end
        WR_RUN: if (wr_done) begin
          wr_addr_q <= wr_addr_d;
          last_wr_q <= 1'b1;
          wr_seen_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ARB;
        end
        RD_REQ: if (sdram_rd_ack) begin
          rd_req_q <= 1'b0;
          state_q  <= RD_RUN;
        end
        RD_RUN: if (rd_done) begin
          rd_addr_q <= rd_addr_d;
          last_wr_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ARB;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  assign sched_busy    = busy_q;
  assign wr_burst_len  = WR_BURST;
  assign rd_burst_len  = RD_BURST;

endmodule
